commit_controller: RTL and testbench

- Commit stage directly downstream of the reorder buffer; consumes the registered commit bus (writeCommit outputBus, flattened to ports here).
- Retires one instruction per cycle:
  - register writeback to the architectural register file;
  - committed stores issued to data memory under a req/ack handshake;
  - branch predictor and BTB updates;
  - misprediction recovery: cpuReset/priorCommit/reset_ptr back to the ROB and a redirect PC to fetch.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/commit_predictor_update.sv | 59 +++++
 rtl/commit_controller.sv | 186 ++++++++++++++++++
 tb/tb_commit_controller.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the commit stage.
// Contents:
//   - bit positions inside the commitInfo and controlFlow bundles
//   - commit_state_t, the commit FSM state encoding
package cpu_pkg;

  // commitInfo = {regWrite, memWrite, jump, branch}
  localparam int REGWRITE = 3;
  localparam int MEMWRITE = 2;
  localparam int JUMP     = 1;
  localparam int BRANCH   = 0;

  // controlFlow = {isControl, nextState[1:0], writeBTB, takenBranch, reset}
  localparam int ISCONTROL    = 5;
  localparam int NEXTSTATE_HI = 4;
  localparam int NEXTSTATE_LO = 3;
  localparam int WRITEBTB     = 2;
  localparam int TAKEN        = 1;
  localparam int RESET        = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } commit_state_t;

endpackage

// File: rtl/commit_predictor_update.sv
// Registered formatter for the branch predictor and BTB update ports.
// Ports:
//   clk, rst                    clock, async active-high reset
//   i_fire                      a control-flow instruction retires this cycle
//   i_branch, i_next_state,
//   i_write_btb, i_taken        predictor fields of the retiring entry
//   i_prev_index, i_old_pc,
//   i_target                    PHT index, instruction PC, resolved target
//   o_btb_*, o_pht_*            update ports, one cycle after i_fire
// o_btb_write and o_pht_update are single-cycle pulses; the data fields
// hold their last value between updates.
module commit_predictor_update #(
  parameter int WIDTH = 31,
  parameter int INDEX = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fire,
  input  logic             i_branch,
  input  logic [1:0]       i_next_state,
  input  logic             i_write_btb,
  input  logic             i_taken,
  input  logic [INDEX:0]   i_prev_index,
  input  logic [WIDTH:0]   i_old_pc,
  input  logic [WIDTH:0]   i_target,
  output logic             o_btb_write,
  output logic [WIDTH:0]   o_btb_pc,
  output logic [WIDTH:0]   o_btb_target,
  output logic             o_pht_update,
  output logic [INDEX:0]   o_pht_index,
  output logic [1:0]       o_pht_state,
  output logic             o_pht_taken
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_btb_write  <= 1'b0;
      o_btb_pc     <= '0;
      o_btb_target <= '0;
      o_pht_update <= 1'b0;
      o_pht_index  <= '0;
      o_pht_state  <= 2'b00;
      o_pht_taken  <= 1'b0;
    end else begin
      o_btb_write  <= 1'b0;
      o_pht_update <= 1'b0;
      if (i_fire) begin
        o_pht_update <= i_branch;
        o_pht_index  <= i_prev_index;
        o_pht_state  <= i_next_state;
        o_pht_taken  <= i_taken;
        o_btb_write  <= i_write_btb;
        o_btb_pc     <= i_old_pc;
        o_btb_target <= i_target;
      end
    end
  end

endmodule

// File: rtl/commit_controller.sv
// Commit stage downstream of the reorder buffer. Retires one entry per
// cycle: register writeback, store issue, predictor/BTB update and
// misprediction recovery.
// Ports:
//   clk, globalReset             clock, async active-high reset
//   validCommit .. commitRob     flattened ROB commit bus
//   memAck                       data memory accepted the store
//   rf*                          architectural register file write port
//   mem*                         store request
//   btb*, pht*                   predictor updates
//   cpuReset, priorCommit,
//   reset_ptr, redirect*         flush / fetch redirect
//   commitStall                  ROB must hold the commit bus
//   dbgState                     current FSM state (commit_state_t)
// Store handshake: memReq is raised with memAddr/memData and all three
// stay stable until a cycle in which memReq=1 and memAck=1; the transfer
// happens on that edge and memReq drops the following cycle. memAck may
// already be high in the first memReq cycle.
module commit_controller
  import cpu_pkg::*;
#(
  parameter int WIDTH        = 31,
  parameter int CONTROL      = 5,
  parameter int INDEX        = 7,
  parameter int ROB          = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             validCommit,
  input  logic [3:0]       commitInfo,
  input  logic [WIDTH:0]   destCommit,
  input  logic [WIDTH:0]   result,
  input  logic [WIDTH:0]   targetAddress,
  input  logic [WIDTH:0]   oldPC,
  input  logic [INDEX:0]   previousIndex,
  input  logic [CONTROL:0] controlFlow,
  input  logic [ROB:0]     commitRob,
  input  logic             memAck,
  output logic             rfWrite,
  output logic [4:0]       rfDest,
  output logic [WIDTH:0]   rfData,
  output logic [ROB:0]     rfRob,
  output logic             memReq,
  output logic [WIDTH:0]   memAddr,
  output logic [WIDTH:0]   memData,
  output logic             btbWrite,
  output logic [WIDTH:0]   btbPC,
  output logic [WIDTH:0]   btbTarget,
  output logic             phtUpdate,
  output logic [INDEX:0]   phtIndex,
  output logic [1:0]       phtState,
  output logic             phtTaken,
  output logic             cpuReset,
  output logic             priorCommit,
  output logic [ROB:0]     reset_ptr,
  output logic             redirect,
  output logic [WIDTH:0]   redirectPC,
  output logic             commitStall,
  output logic [1:0]       dbgState
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  commit_state_t     r_state;
  logic [CNT_W-1:0]  r_flush_cnt;
  // Recovery info of a mispredicting store, replayed once the store is acked.
  logic              r_pend_reset;
  logic [ROB:0]      r_pend_rob;
  logic [WIDTH:0]    r_pend_target;

  logic              w_accept;
  logic              w_unused_jump;

  assign w_accept      = (r_state == ST_IDLE) && validCommit;
  assign w_unused_jump = commitInfo[JUMP];
  assign dbgState      = r_state;
  // Combinational so the ROB holds a store entry in the very cycle it is presented.
  assign commitStall   = (r_state != ST_IDLE) || (validCommit && commitInfo[MEMWRITE]);

  commit_predictor_update #(
    .WIDTH (WIDTH),
    .INDEX (INDEX)
  ) u_pred (
    .clk          (clk),
    .rst          (globalReset),
    .i_fire       (w_accept && controlFlow[ISCONTROL]),
    .i_branch     (commitInfo[BRANCH]),
    .i_next_state (controlFlow[NEXTSTATE_HI:NEXTSTATE_LO]),
    .i_write_btb  (controlFlow[WRITEBTB]),
    .i_taken      (controlFlow[TAKEN]),
    .i_prev_index (previousIndex),
    .i_old_pc     (oldPC),
    .i_target     (targetAddress),
    .o_btb_write  (btbWrite),
    .o_btb_pc     (btbPC),
    .o_btb_target (btbTarget),
    .o_pht_update (phtUpdate),
    .o_pht_index  (phtIndex),
    .o_pht_state  (phtState),
    .o_pht_taken  (phtTaken)
  );

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      r_state       <= ST_IDLE;
      r_flush_cnt   <= '0;
      r_pend_reset  <= 1'b0;
      r_pend_rob    <= '0;
      r_pend_target <= '0;
      rfWrite       <= 1'b0;
      rfDest        <= 5'd0;
      rfData        <= '0;
      rfRob         <= '0;
      memReq        <= 1'b0;
      memAddr       <= '0;
      memData       <= '0;
      cpuReset      <= 1'b0;
      priorCommit   <= 1'b0;
      reset_ptr     <= '0;
      redirect      <= 1'b0;
      redirectPC    <= '0;
    end else begin
      rfWrite     <= 1'b0;
      cpuReset    <= 1'b0;
      priorCommit <= 1'b0;
      redirect    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (validCommit) begin
            if (commitInfo[REGWRITE] && (destCommit[4:0] != 5'd0)) begin
              rfWrite <= 1'b1;
              rfDest  <= destCommit[4:0];
              rfData  <= result;
              rfRob   <= commitRob;
            end
            if (commitInfo[MEMWRITE]) begin
              // A store goes out first even if it mispredicted; recovery waits for the ack.
              memReq        <= 1'b1;
              memAddr       <= destCommit;
              memData       <= result;
              r_pend_reset  <= controlFlow[RESET];
              r_pend_rob    <= commitRob;
              r_pend_target <= targetAddress;
              r_state       <= ST_STORE_WAIT;
            end else if (controlFlow[RESET]) begin
              cpuReset    <= 1'b1;
              priorCommit <= 1'b1;
              reset_ptr   <= commitRob;
              redirect    <= 1'b1;
              redirectPC  <= targetAddress;
              r_flush_cnt <= FLUSH_LOAD;
              r_state     <= ST_FLUSH;
            end
          end
        end
        ST_STORE_WAIT: begin
          if (memAck) begin
            memReq <= 1'b0;
            if (r_pend_reset) begin
              cpuReset    <= 1'b1;
              priorCommit <= 1'b1;
              reset_ptr   <= r_pend_rob;
              redirect    <= 1'b1;
              redirectPC  <= r_pend_target;
              r_flush_cnt <= FLUSH_LOAD;
              r_state     <= ST_FLUSH;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_controller.sv
module tb_commit_controller;

  logic        clk;
  logic        globalReset;
  logic        validCommit;
  logic [3:0]  commitInfo;
  logic [31:0] destCommit;
  logic [31:0] result;
  logic [31:0] targetAddress;
  logic [31:0] oldPC;
  logic [7:0]  previousIndex;
  logic [5:0]  controlFlow;
  logic [2:0]  commitRob;
  logic        memAck;
  logic        rfWrite;
  logic [4:0]  rfDest;
  logic [31:0] rfData;
  logic [2:0]  rfRob;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        btbWrite;
  logic [31:0] btbPC;
  logic [31:0] btbTarget;
  logic        phtUpdate;
  logic [7:0]  phtIndex;
  logic [1:0]  phtState;
  logic        phtTaken;
  logic        cpuReset;
  logic        priorCommit;
  logic [2:0]  reset_ptr;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        commitStall;
  logic [1:0]  dbgState;

  commit_controller dut (
    .clk           (clk),
    .globalReset   (globalReset),
    .validCommit   (validCommit),
    .commitInfo    (commitInfo),
    .destCommit    (destCommit),
    .result        (result),
    .targetAddress (targetAddress),
    .oldPC         (oldPC),
    .previousIndex (previousIndex),
    .controlFlow   (controlFlow),
    .commitRob     (commitRob),
    .memAck        (memAck),
    .rfWrite       (rfWrite),
    .rfDest        (rfDest),
    .rfData        (rfData),
    .rfRob         (rfRob),
    .memReq        (memReq),
    .memAddr       (memAddr),
    .memData       (memData),
    .btbWrite      (btbWrite),
    .btbPC         (btbPC),
    .btbTarget     (btbTarget),
    .phtUpdate     (phtUpdate),
    .phtIndex      (phtIndex),
    .phtState      (phtState),
    .phtTaken      (phtTaken),
    .cpuReset      (cpuReset),
    .priorCommit   (priorCommit),
    .reset_ptr     (reset_ptr),
    .redirect      (redirect),
    .redirectPC    (redirectPC),
    .commitStall   (commitStall),
    .dbgState      (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef enum {
    S_RF_WRITE, S_RF_DEST, S_RF_DATA, S_RF_ROB,
    S_MEM_REQ, S_MEM_ADDR, S_MEM_DATA,
    S_BTB_WRITE, S_BTB_PC, S_BTB_TARGET,
    S_PHT_UPDATE, S_PHT_INDEX, S_PHT_STATE, S_PHT_TAKEN,
    S_CPU_RESET, S_PRIOR_COMMIT, S_RESET_PTR, S_REDIRECT, S_REDIRECT_PC,
    S_STALL, S_STATE
  } sig_e;

  logic [31:0] exp_q[$];
  sig_e        sig_q[$];
  int          n_checks = 0;
  int          n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_RF_WRITE:     return 32'(rfWrite);
      S_RF_DEST:      return 32'(rfDest);
      S_RF_DATA:      return rfData;
      S_RF_ROB:       return 32'(rfRob);
      S_MEM_REQ:      return 32'(memReq);
      S_MEM_ADDR:     return memAddr;
      S_MEM_DATA:     return memData;
      S_BTB_WRITE:    return 32'(btbWrite);
      S_BTB_PC:       return btbPC;
      S_BTB_TARGET:   return btbTarget;
      S_PHT_UPDATE:   return 32'(phtUpdate);
      S_PHT_INDEX:    return 32'(phtIndex);
      S_PHT_STATE:    return 32'(phtState);
      S_PHT_TAKEN:    return 32'(phtTaken);
      S_CPU_RESET:    return 32'(cpuReset);
      S_PRIOR_COMMIT: return 32'(priorCommit);
      S_RESET_PTR:    return 32'(reset_ptr);
      S_REDIRECT:     return 32'(redirect);
      S_REDIRECT_PC:  return redirectPC;
      S_STALL:        return 32'(commitStall);
      S_STATE:        return 32'(dbgState);
      default:        return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push_exp(input sig_e s, input logic [31:0] v);
    sig_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic drain();
    sig_e        s;
    logic [31:0] e;
    while (exp_q.size() != 0) begin
      s = sig_q.pop_front();
      e = exp_q.pop_front();
      check_val(s.name(), observe(s), e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    validCommit   = 1'b0;
    commitInfo    = 4'b0000;
    destCommit    = '0;
    result        = '0;
    targetAddress = '0;
    oldPC         = '0;
    previousIndex = '0;
    controlFlow   = '0;
    commitRob     = '0;
  endtask

  task automatic drive_commit(input logic [3:0] info, input logic [31:0] dest,
                              input logic [31:0] res, input logic [31:0] tgt,
                              input logic [31:0] pc, input logic [7:0] idx,
                              input logic [5:0] cf, input logic [2:0] rob);
    validCommit   = 1'b1;
    commitInfo    = info;
    destCommit    = dest;
    result        = res;
    targetAddress = tgt;
    oldPC         = pc;
    previousIndex = idx;
    controlFlow   = cf;
    commitRob     = rob;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  rob;

    globalReset = 1'b1;
    memAck      = 1'b0;
    idle_bus();
    tick();
    tick();
    // reset state
    push_exp(S_RF_WRITE, 0);  push_exp(S_MEM_REQ, 0);   push_exp(S_MEM_ADDR, 0);
    push_exp(S_BTB_WRITE, 0); push_exp(S_PHT_UPDATE, 0); push_exp(S_CPU_RESET, 0);
    push_exp(S_PRIOR_COMMIT, 0); push_exp(S_REDIRECT, 0); push_exp(S_REDIRECT_PC, 0);
    push_exp(S_RESET_PTR, 0); push_exp(S_STALL, 0); push_exp(S_STATE, 0);
    drain();
    globalReset = 1'b0;
    tick();

    // register write
    drive_commit(4'b1000, 32'd5, 32'hDEADBEEF, 0, 0, 0, 6'b000000, 3'd3);
    tick();
    push_exp(S_RF_WRITE, 1); push_exp(S_RF_DEST, 5); push_exp(S_RF_DATA, 32'hDEADBEEF);
    push_exp(S_RF_ROB, 3); push_exp(S_MEM_REQ, 0); push_exp(S_STALL, 0);
    drain();
    idle_bus();
    tick();
    push_exp(S_RF_WRITE, 0);
    drain();

    // rd = 0 suppresses the write
    drive_commit(4'b1000, 32'd0, 32'h1234, 0, 0, 0, 6'b000000, 3'd1);
    tick();
    push_exp(S_RF_WRITE, 0);
    drain();
    idle_bus();
    tick();

    // store handshake, ack held off for three cycles
    drive_commit(4'b0100, 32'h100, 32'h55, 0, 0, 0, 6'b000000, 3'd2);
    #1;
    push_exp(S_STALL, 1);
    drain();
    tick();
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      push_exp(S_MEM_REQ, 1); push_exp(S_MEM_ADDR, 32'h100); push_exp(S_MEM_DATA, 32'h55);
      push_exp(S_STALL, 1); push_exp(S_STATE, 1);
      drain();
      tick();
    end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    push_exp(S_MEM_REQ, 0); push_exp(S_STATE, 0); push_exp(S_STALL, 0); push_exp(S_CPU_RESET, 0);
    drain();

    // misprediction recovery
    drive_commit(4'b0001, 32'h0, 32'h0, 32'h4000, 32'h80, 8'h11, 6'b111011, 3'd6);
    tick();
    push_exp(S_CPU_RESET, 1); push_exp(S_PRIOR_COMMIT, 1); push_exp(S_RESET_PTR, 6);
    push_exp(S_REDIRECT, 1); push_exp(S_REDIRECT_PC, 32'h4000); push_exp(S_STALL, 1);
    push_exp(S_STATE, 2); push_exp(S_PHT_UPDATE, 1); push_exp(S_PHT_STATE, 3);
    push_exp(S_PHT_TAKEN, 1); push_exp(S_BTB_WRITE, 0);
    drain();
    // a commit presented during the flush is ignored
    drive_commit(4'b1000, 32'd7, 32'h99, 0, 0, 0, 6'b000000, 3'd4);
    tick();
    push_exp(S_CPU_RESET, 0); push_exp(S_PRIOR_COMMIT, 0); push_exp(S_REDIRECT, 0);
    push_exp(S_RF_WRITE, 0); push_exp(S_STALL, 1); push_exp(S_STATE, 2);
    drain();
    idle_bus();
    tick();
    push_exp(S_STALL, 0); push_exp(S_STATE, 0); push_exp(S_RESET_PTR, 6);
    drain();
    drive_commit(4'b1000, 32'd9, 32'h77, 0, 0, 0, 6'b000000, 3'd1);
    tick();
    push_exp(S_RF_WRITE, 1); push_exp(S_RF_DEST, 9); push_exp(S_RF_DATA, 32'h77);
    drain();
    idle_bus();

    // branch predictor / BTB update
    drive_commit(4'b0001, 32'h0, 32'h0, 32'h44, 32'h20, 8'h3A, 6'b101110, 3'd0);
    tick();
    push_exp(S_PHT_UPDATE, 1); push_exp(S_PHT_INDEX, 32'h3A); push_exp(S_PHT_STATE, 1);
    push_exp(S_PHT_TAKEN, 1); push_exp(S_BTB_WRITE, 1); push_exp(S_BTB_PC, 32'h20);
    push_exp(S_BTB_TARGET, 32'h44); push_exp(S_CPU_RESET, 0); push_exp(S_STATE, 0);
    drain();
    idle_bus();
    tick();
    push_exp(S_PHT_UPDATE, 0); push_exp(S_BTB_WRITE, 0);
    drain();

    // mispredicting store, acked in the first memReq cycle
    drive_commit(4'b0100, 32'h200, 32'hAA, 32'h9000, 32'h0, 8'h0, 6'b000001, 3'd2);
    tick();
    push_exp(S_MEM_REQ, 1); push_exp(S_CPU_RESET, 0); push_exp(S_STATE, 1);
    drain();
    idle_bus();
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    push_exp(S_MEM_REQ, 0); push_exp(S_CPU_RESET, 1); push_exp(S_PRIOR_COMMIT, 1);
    push_exp(S_RESET_PTR, 2); push_exp(S_REDIRECT_PC, 32'h9000); push_exp(S_STATE, 2);
    drain();
    tick();
    push_exp(S_CPU_RESET, 0); push_exp(S_STATE, 2); push_exp(S_STALL, 1);
    drain();
    tick();
    push_exp(S_STATE, 0); push_exp(S_STALL, 0);
    drain();

    // reset while waiting for a store ack
    drive_commit(4'b0100, 32'h300, 32'h66, 0, 0, 0, 6'b000000, 3'd5);
    tick();
    idle_bus();
    push_exp(S_MEM_REQ, 1);
    drain();
    #1;
    globalReset = 1'b1;
    #1;
    push_exp(S_MEM_REQ, 0); push_exp(S_STALL, 0); push_exp(S_STATE, 0); push_exp(S_MEM_ADDR, 0);
    drain();
    #1;
    globalReset = 1'b0;
    tick();
    push_exp(S_MEM_REQ, 0); push_exp(S_STATE, 0);
    drain();

    // random register writes
    for (int i = 0; i < 8; i++) begin
      rd   = 5'($urandom_range(1, 31));
      data = $urandom;
      rob  = 3'($urandom_range(0, 7));
      drive_commit(4'b1000, {27'd0, rd}, data, 0, 0, 0, 6'b000000, rob);
      tick();
      push_exp(S_RF_WRITE, 1); push_exp(S_RF_DEST, 32'(rd));
      push_exp(S_RF_DATA, data); push_exp(S_RF_ROB, 32'(rob));
      drain();
    end
    idle_bus();
    tick();
    push_exp(S_RF_WRITE, 0);
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
